// File: rtl/map_wr_arbiter.sv
// Arbitrates three tile-map writers (explosion engine first, players round-robin), with optional write-if-empty.
// Latency: 2 cycles unconditional, 4 cycles conditional success, 3 cycles conditional reject.
// Backpressure: requesters hold their request until req_done; map_ready low blocks grants and aborts in-flight work.
module map_wr_arbiter #(
    parameter  int NUM_ROW    = 11,
    parameter  int NUM_COL    = 19,
    parameter  int DATA_WIDTH = 2,
    localparam int DEPTH      = NUM_ROW * NUM_COL,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            map_ready,
    input  logic [2:0]                      req_valid,
    input  logic [2:0][ADDR_WIDTH-1:0]      req_addr,
    input  logic [2:0][DATA_WIDTH-1:0]      req_data,
    input  logic [2:0]                      req_cond,
    output logic [2:0]                      req_done,
    output logic                            req_ok,
    output logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            we,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [DATA_WIDTH-1:0]           wr_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, CHK, WR} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    bad_q, bad_d;
    // rr_q=1 means player 2 wins the next tie between the players.
    logic                    rr_q, rr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic [1:0]              gnt_id;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic                    gnt_cond;
    logic                    gnt_bad;
    logic                    we_c;
    logic                    ok_c;
    logic [2:0]              done_c;

    always_comb begin
        gnt_id = 2'd0;
        if (req_valid[0]) begin
            gnt_id = 2'd0;
        end else if (req_valid[1] && req_valid[2]) begin
            gnt_id = rr_q ? 2'd2 : 2'd1;
        end else if (req_valid[1]) begin
            gnt_id = 2'd1;
        end else if (req_valid[2]) begin
            gnt_id = 2'd2;
        end
        gnt_addr = req_addr[gnt_id];
        gnt_data = req_data[gnt_id];
        gnt_cond = req_cond[gnt_id];
        gnt_bad  = ({1'b0, gnt_addr} >= DEPTH_W);
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bad_d     = bad_q;
        rr_d      = rr_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we_c      = 1'b0;
        ok_c      = 1'b0;
        done_c    = 3'b000;
        case (state_q)
            IDLE: begin
                if (map_ready && (|req_valid)) begin
                    id_d   = gnt_id;
                    addr_d = gnt_addr;
                    data_d = gnt_data;
                    bad_d  = gnt_bad;
                    if (gnt_id != 2'd0) begin
                        rr_d = (gnt_id == 2'd1);
                    end
                    // Out-of-range addresses take the WR slot as a reject-only done cycle.
                    if (gnt_bad) begin
                        state_d = WR;
                    end else if (gnt_cond) begin
                        state_d   = RD;
                        rd_addr_d = gnt_addr;
                    end else begin
                        state_d   = WR;
                        wr_addr_d = gnt_addr;
                        wr_data_d = gnt_data;
                    end
                end
            end
            RD: begin
                state_d = map_ready ? CHK : IDLE;
            end
            CHK: begin
                if (!map_ready) begin
                    state_d = IDLE;
                end else if (rd_data == '0) begin
                    state_d   = WR;
                    wr_addr_d = addr_q;
                    wr_data_d = data_q;
                end else begin
                    state_d        = IDLE;
                    done_c[id_q]   = 1'b1;
                end
            end
            WR: begin
                state_d = IDLE;
                if (map_ready) begin
                    done_c[id_q] = 1'b1;
                    ok_c         = ~bad_q;
                    we_c         = ~bad_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= 2'd0;
            addr_q    <= '0;
            data_q    <= '0;
            bad_q     <= 1'b0;
            rr_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bad_q     <= bad_d;
            rr_q      <= rr_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Outputs are held at zero for the whole reset cycle, not just after the edge.
    assign we       = we_c & ~rst;
    assign req_ok   = ok_c & ~rst;
    assign req_done = rst ? 3'b000 : done_c;
    assign rd_addr  = rst ? '0 : rd_addr_q;
    assign wr_addr  = rst ? '0 : wr_addr_q;
    assign wr_data  = rst ? '0 : wr_data_q;

endmodule

// File: tb/tb_map_wr_arbiter.sv
// Directed bench for map_wr_arbiter: vector table for single transactions plus arbitration/abort/reset sequences.
module tb_map_wr_arbiter;

    logic             clk;
    logic             rst;
    logic             map_ready;
    logic [2:0]       req_valid;
    logic [2:0][7:0]  req_addr;
    logic [2:0][1:0]  req_data;
    logic [2:0]       req_cond;
    logic [2:0]       req_done;
    logic             req_ok;
    logic [7:0]       rd_addr;
    logic [1:0]       rd_data;
    logic             we;
    logic [7:0]       wr_addr;
    logic [1:0]       wr_data;

    int total = 0;
    int bad   = 0;

    map_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .map_ready (map_ready),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_cond  (req_cond),
        .req_done  (req_done),
        .req_ok    (req_ok),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Watches n cycles; releases each requester on the edge where its done was high.
    task automatic mon(input int n, input int rd_c,
                       output int d_cyc, output int d_val, output int d_ok, output int d_n,
                       output int w_n, output int w_cyc, output int w_a, output int w_d,
                       output int rd_a);
        logic [2:0] dv;
        d_cyc = 0; d_val = 0; d_ok = 0; d_n = 0;
        w_n = 0; w_cyc = 0; w_a = 0; w_d = 0; rd_a = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            dv = req_done;
            if (c == rd_c) rd_a = int'(rd_addr);
            if (dv != 3'b000) begin
                d_n++;
                if (d_cyc == 0) begin
                    d_cyc = c; d_val = int'(dv); d_ok = int'(req_ok);
                end
            end
            if (we) begin
                w_n++; w_cyc = c; w_a = int'(wr_addr); w_d = int'(wr_data);
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~dv;
        end
    endtask

    typedef struct {
        int who; int addr; int data; int cond; int tile;
        int done_cyc; int ok; int we_cyc; int rd_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a;
        int n;
        int exp_seq[6];
        int got_seq[6];
        int ev;

        vecs[0] = '{0,  40, 3, 0, 0, 2, 1, 2, 0};
        vecs[1] = '{1,  20, 1, 1, 0, 4, 1, 4, 2};
        vecs[2] = '{1,  21, 1, 1, 2, 3, 0, 0, 2};
        vecs[3] = '{2, 208, 2, 0, 0, 2, 1, 2, 0};
        vecs[4] = '{0, 209, 1, 0, 0, 2, 0, 0, 0};
        vecs[5] = '{2, 255, 3, 1, 0, 2, 0, 0, 0};
        vecs[6] = '{2,   0, 1, 1, 3, 3, 0, 0, 2};
        vecs[7] = '{0, 100, 2, 1, 0, 4, 1, 4, 2};

        rst = 1'b1; map_ready = 1'b1; req_valid = '0; req_addr = '0;
        req_data = '0; req_cond = '0; rd_data = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", int'({we, req_done, req_ok, rd_addr, wr_addr, wr_data}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rd_data = 2'(vecs[i].tile);
            req_addr[vecs[i].who]  = 8'(vecs[i].addr);
            req_data[vecs[i].who]  = 2'(vecs[i].data);
            req_cond[vecs[i].who]  = vecs[i].cond[0];
            req_valid[vecs[i].who] = 1'b1;
            mon(6, vecs[i].rd_cyc, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
            req_valid = '0;
            chk($sformatf("v%0d_done_cycle", i), d_cyc, vecs[i].done_cyc);
            chk($sformatf("v%0d_done_bits", i), d_val, 1 << vecs[i].who);
            chk($sformatf("v%0d_done_count", i), d_n, 1);
            chk($sformatf("v%0d_ok", i), d_ok, vecs[i].ok);
            chk($sformatf("v%0d_we_count", i), w_n, (vecs[i].we_cyc != 0) ? 1 : 0);
            if (vecs[i].we_cyc != 0) begin
                chk($sformatf("v%0d_we_cycle", i), w_cyc, vecs[i].we_cyc);
                chk($sformatf("v%0d_wr_addr", i), w_a, vecs[i].addr);
                chk($sformatf("v%0d_wr_data", i), w_d, vecs[i].data);
            end
            if (vecs[i].rd_cyc != 0)
                chk($sformatf("v%0d_rd_addr", i), rd_a, vecs[i].addr);
        end

        // Players held continuously; explosion engine cuts in after the fourth grant.
        exp_seq = '{2, 4, 2, 4, 1, 2};
        got_seq = '{0, 0, 0, 0, 0, 0};
        @(posedge clk); #1;
        req_addr[1] = 8'd50; req_data[1] = 2'd1; req_cond[1] = 1'b0;
        req_addr[2] = 8'd51; req_data[2] = 2'd2; req_cond[2] = 1'b0;
        req_addr[0] = 8'd60; req_data[0] = 2'd3; req_cond[0] = 1'b0;
        req_valid = 3'b110;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            logic drop0;
            drop0 = 1'b0;
            @(negedge clk);
            if (req_done != 3'b000) begin
                got_seq[n] = int'(req_done);
                n++;
                if (req_done == 3'b001) drop0 = 1'b1;
                if (n == 4) req_valid[0] = 1'b1;
            end
            @(posedge clk); #1;
            if (drop0) req_valid[0] = 1'b0;
        end
        req_valid = '0;
        chk("rr_grant_count", n, 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_grant_%0d", k), got_seq[k], exp_seq[k]);

        // No grant while the map is not ready.
        @(posedge clk); #1;
        map_ready = 1'b0;
        req_addr[1] = 8'd5; req_data[1] = 2'd1; req_cond[1] = 1'b0; req_valid[1] = 1'b1;
        mon(4, 0, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
        chk("notready_done_count", d_n, 0);
        chk("notready_we_count", w_n, 0);
        map_ready = 1'b1;
        mon(4, 0, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
        req_valid = '0;
        chk("ready_done_cycle", d_cyc, 2);
        chk("ready_wr_addr", w_a, 5);

        // map_ready drops while in CHK: abort, then full retry.
        @(posedge clk); #1;
        rd_data = 2'd0;
        req_addr[2] = 8'd7; req_data[2] = 2'd2; req_cond[2] = 1'b1; req_valid[2] = 1'b1;
        mon(2, 2, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
        chk("abort_rd_addr", rd_a, 7);
        ev = d_n + w_n;
        map_ready = 1'b0;
        mon(4, 0, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
        chk("abort_no_events", ev + d_n + w_n, 0);
        map_ready = 1'b1;
        mon(6, 0, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
        req_valid = '0;
        chk("retry_done_cycle", d_cyc, 4);
        chk("retry_done_bits", d_val, 4);
        chk("retry_ok", d_ok, 1);
        chk("retry_wr_addr", w_a, 7);

        // Reset during RD after a player-1 grant (pointer then favours player 2).
        @(posedge clk); #1;
        req_addr[1] = 8'd30; req_data[1] = 2'd1; req_cond[1] = 1'b1; req_valid[1] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        chk("rst_cycle_outputs", int'({we, req_done, req_ok, rd_addr, wr_addr, wr_data}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", int'({we, req_done, req_ok, rd_addr, wr_addr, wr_data}), 0);
        @(posedge clk); #1;
        req_addr[1] = 8'd11; req_data[1] = 2'd1; req_cond[1] = 1'b0;
        req_addr[2] = 8'd12; req_data[2] = 2'd2; req_cond[2] = 1'b0;
        req_valid = 3'b110;
        mon(6, 0, d_cyc, d_val, d_ok, d_n, w_n, w_cyc, w_a, w_d, rd_a);
        req_valid = '0;
        chk("post_rst_tie_winner", d_val, 2);
        chk("post_rst_tie_cycle", d_cyc, 2);
        chk("post_rst_done_count", d_n, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_wr_arbiter.md
MAP_WR_ARBITER -- requirements
Module: map_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_ROW, default 11, tile grid rows.
REQ-002 SHALL have parameter NUM_COL, default 19, tile grid columns.
REQ-003 SHALL have parameter DATA_WIDTH, default 2, tile entry width; DEPTH = NUM_ROW*NUM_COL and ADDR_WIDTH = $clog2(DEPTH) are derived localparams.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port map_ready  input  1  high when the tile map is initialised and accepts writes.
REQ-007 SHALL have port req_valid  input  [2:0]  per-requester request; 0 = explosion engine, 1 = player 1, 2 = player 2.
REQ-008 SHALL have port req_addr  input  [2:0][ADDR_WIDTH-1:0]  per-requester tile address.
REQ-009 SHALL have port req_data  input  [2:0][DATA_WIDTH-1:0]  per-requester tile value.
REQ-010 SHALL have port req_cond  input  [2:0]  1 = write only if the tile currently reads 0 (no_blk).
REQ-011 SHALL have port req_done  output  [2:0]  one-cycle completion pulse to the served requester.
REQ-012 SHALL have port req_ok  output  1  valid with req_done; 1 = write performed, 0 = rejected.
REQ-013 SHALL have port rd_addr  output  ADDR_WIDTH  map read address; read data returns one cycle later.
REQ-014 SHALL have port rd_data  input  DATA_WIDTH  map read data.
REQ-015 SHALL have ports we (output, 1), wr_addr (output, ADDR_WIDTH) and wr_data (output, DATA_WIDTH) driving the map write port.

Function
REQ-016 SHALL implement FSM states IDLE, RD, CHK and WR; only one request is in service at a time.
REQ-017 SHALL, in IDLE with map_ready=1 and any req_valid set, grant one requester and latch its addr, data, cond and id.
REQ-018 SHALL give requester 0 absolute priority and alternate between requesters 1 and 2 via a round-robin pointer.
REQ-019 SHALL advance the round-robin pointer only when a player is granted; after reset, player 1 wins the first tie.
REQ-020 SHALL, on grant, go to RD if cond=1 and to WR if cond=0.
REQ-021 SHALL reject a latched address >= DEPTH: go directly to a done cycle with req_ok=0 and no read or write (in place of RD/WR).
REQ-022 SHALL drive rd_addr from the latched address during RD and move to CHK.
REQ-023 SHALL, in CHK, go to WR if rd_data == 0; otherwise pulse req_done[id] with req_ok=0 and return to IDLE.
REQ-024 SHALL, in WR, assert we for exactly one cycle with the latched wr_addr and wr_data, pulse req_done[id] with req_ok=1 in the same cycle, and return to IDLE.
REQ-025 SHALL drive we, req_done and req_ok from the FSM state and latched registers only, never combinationally from req_* inputs.
REQ-026 SHALL give unconditional latency of 2 cycles: the grant cycle, then the WR/done cycle.
REQ-027 SHALL give conditional latency of 4 cycles on success (IDLE, RD, CHK, WR) and 3 cycles on rejection (done in CHK).
REQ-028 SHALL expect each requester to hold valid, addr, data and cond stable until its req_done, and to drop req_valid on the edge at which req_done is high; the arbiter samples the next IDLE cycle with that assumption.
REQ-029 SHALL never assert req_done for a requester that was not granted, and never more than one req_done bit at a time.
REQ-030 SHALL, if map_ready falls in RD, CHK or WR, abort to IDLE without we or req_done; the request is re-arbitrated once map_ready returns.
REQ-031 SHALL ignore req_valid while not in IDLE; new or changed requests wait.
REQ-032 SHALL hold rd_addr, wr_addr and wr_data at their last value when unused.

Reset
REQ-033 SHALL, while rst=1, force state IDLE, we=0, req_done=0, req_ok=0, rd_addr=0, wr_addr=0, wr_data=0, and the round-robin pointer to favour player 1.
REQ-034 SHALL, on rst asserted mid-operation, abandon the request with no write and no done pulse.

Verification
REQ-035 SHALL cover: req0 valid, addr=40, data=3, cond=0 -> we=1, wr_addr=40, wr_data=3 in cycle 2, req_done=3'b001, req_ok=1.
REQ-036 SHALL cover: req1 cond=1, addr=20, tile reads 0 -> rd_addr=20 in cycle 2, we in cycle 4, req_ok=1; repeat with tile reading 2 -> done in cycle 3, req_ok=0, no we.
REQ-037 SHALL cover: req1 and req2 held continuously -> grants alternate 1,2,1,2; asserting req0 mid-stream -> req0 is served at the next IDLE.
REQ-038 SHALL cover: addr=209 with defaults -> req_ok=0 in the cycle after the grant, we never asserted.
REQ-039 SHALL cover: map_ready=0 with requests pending -> no grant; map_ready dropped during CHK -> no we and no done, then served after map_ready=1.
REQ-040 SHALL cover: rst pulsed during RD -> all outputs 0 next cycle, and the first post-reset player tie goes to player 1.
